alu_seq: RTL and testbench

- Parametrised, clocked successor to the datapath ALU.
- Widens to W bits and extends the opcode to 3 bits, adding OR, XOR, logical shift-left and a multi-cycle unsigned multiply.
- Produces registered result and Z/N/V flags for every operation; the existing ALU computes flags only for subtract.
- Sits between the register-file operand latches and the writeback/status registers. The controller uses a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/shift_add_mul.sv | 67 ++++++
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - 3-bit opcode constants OP_ADD..OP_MUL
//   - bit positions of the {Z,N,V} flags in the status word
//   - FSM state encoding for the controller in alu_seq
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_LSL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - capture A/B, clear accumulator and counter
//   step        - accumulate one multiplier bit (LSB first)
//   A, B        - operands (W bits)
//   product     - accumulator value including the current step (2W bits)
//   last        - the current step is the W-th one
module shift_add_mul #(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] product,
    output logic           last
);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_sum;

    // product exposes the post-step sum so the controller can capture the
    // final result on the same edge as the last step.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = acc_sum;
    assign last    = (cnt_q == CW'(W - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{W{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked W-bit ALU with start/busy/done handshake.
// Single-cycle ops complete on the accepting edge; MUL runs W shift-add steps.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - request; sampled when busy=0
//   Ain, Bin, ALUop - operands and 3-bit opcode
//   busy            - multiply in progress
//   done            - one-cycle pulse when out/status are freshly updated
//   out, status     - registered result and {Z,N,V}
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic [2:0]   status
);

    localparam int SHW = $clog2(W);

    state_t         state_q, state_d;
    logic [W-1:0]   out_q, out_d;
    logic [2:0]     status_q, status_d;
    logic           done_q, done_d;

    logic           mul_load, mul_step, mul_last;
    logic [2*W-1:0] mul_product;

    logic [W-1:0]   alu_res;
    logic           alu_v;

    shift_add_mul #(.W(W), .CW(CW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .step    (mul_step),
        .A       (Ain),
        .B       (Bin),
        .product (mul_product),
        .last    (mul_last)
    );

    // Single-cycle datapath. Overflow uses the sign rule, which is
    // equivalent to carry-in XOR carry-out of the MSB.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                alu_res = Ain + Bin;
                alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
            end
            OP_SUB: begin
                alu_res = Ain - Bin;
                alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
            end
            OP_AND:  alu_res = Ain & Bin;
            OP_NOTB: alu_res = ~Bin;
            OP_OR:   alu_res = Ain | Bin;
            OP_XOR:  alu_res = Ain ^ Bin;
            OP_LSL:  alu_res = Ain << Bin[SHW-1:0];
            default: alu_res = '0;  // MUL goes through the iterative path
        endcase
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        status_d = status_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ALUop == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        out_d            = alu_res;
                        status_d[FLAG_Z] = (alu_res == '0);
                        status_d[FLAG_N] = alu_res[W-1];
                        status_d[FLAG_V] = alu_v;
                        done_d           = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately ignored here; operands stay frozen
                mul_step = 1'b1;
                if (mul_last) begin
                    out_d            = mul_product[W-1:0];
                    status_d[FLAG_Z] = (mul_product[W-1:0] == '0);
                    status_d[FLAG_N] = mul_product[W-1];
                    status_d[FLAG_V] = |mul_product[2*W-1:W];
                    done_d           = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            status_q <= 3'b000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ST_MUL);
    assign done   = done_q;
    assign out    = out_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         busy, done;
    logic [W-1:0] out;
    logic [2:0]   status;

    always #5 clk = ~clk;

    alu_seq #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Ain    (a),
        .Bin    (b),
        .ALUop  (op),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .status (status)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference: plain integer arithmetic, returns {result, Z, N, V}
    function automatic logic [W+2:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux, uy, r, s;
        longint smax, smin;
        logic [W-1:0] res;
        logic v;
        ux = longint'(x);
        uy = longint'(y);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        v = 1'b0;
        r = 0;
        case (o)
            3'd0: begin r = ux + uy; s = longint'($signed(x)) + longint'($signed(y)); v = (s > smax) || (s < smin); end
            3'd1: begin r = ux - uy; s = longint'($signed(x)) - longint'($signed(y)); v = (s > smax) || (s < smin); end
            3'd2: r = ux & uy;
            3'd3: r = ~uy;
            3'd4: r = ux | uy;
            3'd5: r = ux ^ uy;
            3'd6: r = ux << (uy % W);
            default: begin r = ux * uy; v = (r >> W) != 0; end
        endcase
        res = W'(r & ((longint'(1) << W) - 1));
        return {res, res == '0, res[W-1], v};
    endfunction

    logic [W+2:0] m_ref;
    assign m_ref = ref_op(op, a, b);

    logic [W-1:0] m_out, m_pend_out;
    logic [2:0]   m_status, m_pend_st;
    logic         m_done;
    int           m_left;
    bit           m_valid = 1'b0;

    // Behavioural model: MUL takes W edges after acceptance, others complete
    // on the accepting edge; requests while a multiply runs are dropped.
    always @(posedge clk) begin
        if (reset) begin
            m_out    <= '0;
            m_status <= '0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_valid  <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_out    <= m_pend_out;
                m_status <= m_pend_st;
            end
        end else if (start) begin
            if (op == 3'b111) begin
                m_left     <= W;
                m_pend_out <= m_ref[W+2:3];
                m_pend_st  <= m_ref[2:0];
                m_done     <= 1'b0;
            end else begin
                m_out    <= m_ref[W+2:3];
                m_status <= m_ref[2:0];
                m_done   <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("done",   done,   m_done);
            chk("busy",   busy,   m_left > 0);
            chk("out",    out,    m_out);
            chk("status", status, m_status);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    int lat;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 16'h0000);
        chk("rst_status", status, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;

        issue(3'b000, 16'h7FFF, 16'h0001);
        chk("add_ovf_done", done, 1'b1);
        chk("add_ovf_out", out, 16'h8000);
        chk("add_ovf_st", status, 3'b011);

        issue(3'b001, 16'h1234, 16'h1234);
        chk("sub_zero_out", out, 16'h0000);
        chk("sub_zero_st", status, 3'b100);
        issue(3'b001, 16'h8000, 16'h0001);
        chk("sub_ovf_out", out, 16'h7FFF);
        chk("sub_ovf_st", status, 3'b001);

        // start held high across three accepted ops
        start = 1'b1; op = 3'b100; a = 16'hF0F0; b = 16'h0F0F;
        @(negedge clk);
        chk("b2b_or_done", done, 1'b1);
        chk("b2b_or_out", out, 16'hFFFF);
        chk("b2b_or_st", status, 3'b010);
        op = 3'b101;
        @(negedge clk);
        chk("b2b_xor_done", done, 1'b1);
        chk("b2b_xor_out", out, 16'hFFFF);
        chk("b2b_xor_st", status, 3'b010);
        op = 3'b110; a = 16'h0003; b = 16'h0004;
        @(negedge clk);
        chk("b2b_lsl_done", done, 1'b1);
        chk("b2b_lsl_out", out, 16'h0030);
        chk("b2b_lsl_st", status, 3'b000);
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 1'b0);

        issue(3'b111, 16'h0100, 16'h0200);
        chk("mul_busy", busy, 1'b1);
        wait_done(lat);
        chk("mul_latency", lat, 16);
        chk("mul1_out", out, 16'h0000);
        chk("mul1_st", status, 3'b101);

        issue(3'b111, 16'h00FF, 16'h0003);
        wait_done(lat);
        chk("mul2_out", out, 16'h02FD);
        chk("mul2_st", status, 3'b000);

        // start during busy must be ignored
        issue(3'b111, 16'h0003, 16'h0005);
        repeat (3) @(negedge clk);
        issue(3'b000, 16'h0001, 16'h0001);
        chk("busy_ign_done", done, 1'b0);
        chk("busy_ign_out", out, 16'h02FD);
        wait_done(lat);
        chk("mul3_out", out, 16'h000F);
        chk("mul3_st", status, 3'b000);
        @(negedge clk);
        chk("mul3_single_done", done, 1'b0);

        // reset aborts a multiply
        issue(3'b111, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_out", out, 16'h0000);
        chk("abort_st", status, 3'b000);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done, 1'b0);

        issue(3'b000, 16'h0002, 16'h0003);
        chk("post_add_done", done, 1'b1);
        chk("post_add_out", out, 16'h0005);
        chk("post_add_st", status, 3'b000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
